// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB phase FSM, combinational
// datapath enables/selects, and a retired-instruction counter.
module mccpu_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic [5:0]  Op,
   input  logic [5:0]  Funct,
   input  logic        Zero,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        ALUSrcA,
   output logic        ALUSrcB,
   output logic        EXTOp,
   output logic [2:0]  ALUOp,
   output logic        WDSel,
   output logic        GPRSel,
   output logic [1:0]  NPCOp,
   output logic        illegal,
   output logic [31:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
   localparam logic [5:0] F_SLL  = 6'b000000;

   localparam logic [2:0] ALU_NOP  = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b111;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        retire;
   logic        r_legal;
   logic        op_legal;
   logic [2:0]  r_aluop;

   always_comb begin
      r_legal = 1'b1;
      r_aluop = ALU_NOP;
      case (Funct)
         F_ADD:   r_aluop = ALU_ADD;
         F_SUB:   r_aluop = ALU_SUB;
         F_AND:   r_aluop = ALU_AND;
         F_OR:    r_aluop = ALU_OR;
         F_SLT:   r_aluop = ALU_SLT;
         F_SLTU:  r_aluop = ALU_SLTU;
         F_SLL:   r_aluop = ALU_SLL;
         default: r_legal = 1'b0;
      endcase
   end

   always_comb begin
      case (Op)
         OP_R:                                         op_legal = r_legal;
         OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
         default:                                      op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 1'b0;
      EXTOp    = 1'b0;
      ALUOp    = ALU_NOP;
      WDSel    = 1'b0;
      GPRSel   = 1'b0;
      NPCOp    = NPC_PLUS4;
      illegal  = 1'b0;
      case (state_q)
         S_IF: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            if (!op_legal) begin
               illegal = 1'b1;
               state_d = S_IF;
            end else if (Op == OP_J) begin
               PCWrite = 1'b1;
               NPCOp   = NPC_JUMP;
               retire  = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            case (Op)
               OP_R: begin
                  ALUOp   = r_aluop;
                  ALUSrcA = (Funct == F_SLL);
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  ALUSrcB = 1'b1;
                  EXTOp   = 1'b1;
                  ALUOp   = ALU_ADD;
                  state_d = S_WB;
               end
               OP_ORI: begin
                  ALUSrcB = 1'b1;
                  ALUOp   = ALU_OR;
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  ALUSrcB = 1'b1;
                  EXTOp   = 1'b1;
                  ALUOp   = ALU_ADD;
                  state_d = S_MEM;
               end
               OP_BEQ: begin
                  ALUOp   = ALU_SUB;
                  NPCOp   = NPC_BRANCH;
                  PCWrite = Zero;
                  retire  = 1'b1;
                  state_d = S_IF;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            if (Op == OP_SW) begin
               MemWrite = 1'b1;
               retire   = 1'b1;
               state_d  = S_IF;
            end else if (Op == OP_LW) begin
               state_d = S_WB;
            end else begin
               state_d = S_IF;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            GPRSel   = (Op != OP_R);
            WDSel    = (Op == OP_LW);
            retire   = 1'b1;
            state_d  = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   // Counter wraps naturally at 32 bits.
   always_comb begin
      cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IF;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_cnt = cnt_q;

endmodule
